// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use and branch-compare hazard detection.
// A detected hazard freezes PC and IF/ID and turns the next EX instruction into a bubble.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        destIn,
    input  logic              usesRt,
    input  logic              isBranch,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] sExtend,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic [4:0]        ex_memRdOut,
    input  logic              ex_memMemReadOut,
    output logic [4:0]        id_exRsOut,
    output logic [4:0]        id_exRtOut,
    output logic [4:0]        id_exDestOut,
    output logic [DATA_W-1:0] id_exData1Out,
    output logic [DATA_W-1:0] id_exData2Out,
    output logic [DATA_W-1:0] id_exImmOut,
    output logic [CTRL_W-1:0] id_exCtrlOut,
    output logic              id_exRegWriteOut,
    output logic              pcWrite,
    output logic              if_idWrite,
    output logic              stall,
    output logic [CNT_W-1:0]  stallCount
);

    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        dest_q, dest_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic stall_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Hazard detection against the instruction in EX (ID/EX) and in MEM (EX/MEM)
    always_comb begin
        load_use = ctrl_q[1] && (rt_q != 5'd0) &&
                   ((rt_q == Rs) || (usesRt && (rt_q == Rt)));
        br_ex    = isBranch && ctrl_q[0] && (dest_q != 5'd0) &&
                   ((dest_q == Rs) || (dest_q == Rt));
        br_mem   = isBranch && ex_memMemReadOut && (ex_memRdOut != 5'd0) &&
                   ((ex_memRdOut == Rs) || (ex_memRdOut == Rt));
        stall_c  = !rst && (load_use || br_ex || br_mem);
    end

    // Operand fields are captured even on a stall so bubble contents stay deterministic
    always_comb begin
        rs_d        = Rs;
        rt_d        = Rt;
        dest_d      = destIn;
        data1_d     = readData1;
        data2_d     = readData2;
        imm_d       = sExtend;
        ctrl_d      = stall_c ? '0 : ctrlIn;
        stall_cnt_d = stall_c ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dest_q      <= dest_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_exRsOut       = rs_q;
    assign id_exRtOut       = rt_q;
    assign id_exDestOut     = dest_q;
    assign id_exData1Out    = data1_q;
    assign id_exData2Out    = data2_q;
    assign id_exImmOut      = imm_q;
    assign id_exCtrlOut     = ctrl_q;
    assign id_exRegWriteOut = ctrl_q[0];
    assign stall            = stall_c;
    assign pcWrite          = !stall_c;
    assign if_idWrite       = !stall_c;
    assign stallCount       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed table-driven bench for id_ex_hazard_stage; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_id_ex_hazard_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        Rs, Rt, destIn, ex_memRdOut;
    logic              usesRt, isBranch, ex_memMemReadOut;
    logic [DATA_W-1:0] readData1, readData2, sExtend;
    logic [CTRL_W-1:0] ctrlIn;

    logic [4:0]        rsOut, rtOut, destOut;
    logic [DATA_W-1:0] d1Out, d2Out, immOut;
    logic [CTRL_W-1:0] ctrlOut;
    logic              regWrOut, pcWrite, if_idWrite, stall;
    logic [15:0]       stallCount;

    logic [4:0]        s_rsOut, s_rtOut, s_destOut;
    logic [DATA_W-1:0] s_d1Out, s_d2Out, s_immOut;
    logic [CTRL_W-1:0] s_ctrlOut;
    logic              s_regWrOut, s_pcWrite, s_if_idWrite, s_stall;
    logic [1:0]        s_stallCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Rs(Rs), .Rt(Rt), .destIn(destIn), .usesRt(usesRt),
        .isBranch(isBranch), .readData1(readData1), .readData2(readData2),
        .sExtend(sExtend), .ctrlIn(ctrlIn), .ex_memRdOut(ex_memRdOut),
        .ex_memMemReadOut(ex_memMemReadOut), .id_exRsOut(rsOut), .id_exRtOut(rtOut),
        .id_exDestOut(destOut), .id_exData1Out(d1Out), .id_exData2Out(d2Out),
        .id_exImmOut(immOut), .id_exCtrlOut(ctrlOut), .id_exRegWriteOut(regWrOut),
        .pcWrite(pcWrite), .if_idWrite(if_idWrite), .stall(stall), .stallCount(stallCount)
    );

    id_ex_hazard_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .Rs(Rs), .Rt(Rt), .destIn(destIn), .usesRt(usesRt),
        .isBranch(isBranch), .readData1(readData1), .readData2(readData2),
        .sExtend(sExtend), .ctrlIn(ctrlIn), .ex_memRdOut(ex_memRdOut),
        .ex_memMemReadOut(ex_memMemReadOut), .id_exRsOut(s_rsOut), .id_exRtOut(s_rtOut),
        .id_exDestOut(s_destOut), .id_exData1Out(s_d1Out), .id_exData2Out(s_d2Out),
        .id_exImmOut(s_immOut), .id_exCtrlOut(s_ctrlOut), .id_exRegWriteOut(s_regWrOut),
        .pcWrite(s_pcWrite), .if_idWrite(s_if_idWrite), .stall(s_stall),
        .stallCount(s_stallCount)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, dest;
        logic       uses, br;
        logic [7:0] ctrl;
        logic [4:0] xrd;
        logic       xmr;
        logic       e_stall;
        logic [7:0] e_ctrl;
        logic [4:0] e_rs, e_rt, e_dest;
        int         e_cnt;
        int         e_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic uses, input logic br,
                       input logic [7:0] ctrl, input logic [4:0] xrd, input logic xmr,
                       input logic es, input logic [7:0] ec, input logic [4:0] ers,
                       input logic [4:0] ert, input logic [4:0] ed, input int cnt,
                       input int sat);
        vec_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.dest = dest; v.uses = uses; v.br = br;
        v.ctrl = ctrl; v.xrd = xrd; v.xmr = xmr; v.e_stall = es; v.e_ctrl = ec;
        v.e_rs = ers; v.e_rt = ert; v.e_dest = ed; v.e_cnt = cnt; v.e_sat = sat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic uses, input logic br,
                         input logic [7:0] ctrl, input logic [4:0] xrd, input logic xmr,
                         input int idx);
        rst = r; Rs = rs; Rt = rt; destIn = dest; usesRt = uses; isBranch = br;
        ctrlIn = ctrl; ex_memRdOut = xrd; ex_memMemReadOut = xmr;
        readData1 = 32'hA000_0000 | idx;
        readData2 = 32'hB000_0000 | idx;
        sExtend   = 32'hFFFF_FF00 | idx;
    endtask

    initial begin
        // rst  rs rt de us br ctrl  xrd xmr | stall ctrl  rs rt de cnt sat
        add(1, 8, 8, 8, 1, 1, 8'h03, 5, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8, 8, 8, 1, 1, 8'h03, 5, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8, 8, 0, 0, 8'h03, 0, 0,   0, 8'h03, 1, 8, 8, 0, 0);
        add(0, 8, 2, 9, 1, 0, 8'h01, 0, 0,   1, 8'h00, 8, 2, 9, 1, 1);
        add(0, 8, 2, 9, 1, 0, 8'h01, 0, 0,   0, 8'h01, 8, 2, 9, 1, 1);
        add(0, 1, 8, 8, 0, 0, 8'h03, 0, 0,   0, 8'h03, 1, 8, 8, 1, 1);
        add(0, 3, 8, 8, 0, 0, 8'h21, 0, 0,   0, 8'h21, 3, 8, 8, 1, 1);
        add(0, 2, 5, 5, 0, 0, 8'h03, 0, 0,   0, 8'h03, 2, 5, 5, 1, 1);
        add(0, 5, 6, 0, 1, 1, 8'h40, 8, 0,   1, 8'h00, 5, 6, 0, 2, 2);
        add(0, 5, 6, 0, 1, 1, 8'h40, 5, 1,   1, 8'h00, 5, 6, 0, 3, 3);
        add(0, 5, 6, 0, 1, 1, 8'h40, 0, 0,   0, 8'h40, 5, 6, 0, 3, 3);
        add(0, 1, 2, 3, 1, 0, 8'h01, 0, 0,   0, 8'h01, 1, 2, 3, 3, 3);
        add(0, 7, 3, 0, 1, 1, 8'h40, 0, 0,   1, 8'h00, 7, 3, 0, 4, 3);
        add(0, 7, 3, 0, 1, 1, 8'h40, 3, 0,   0, 8'h40, 7, 3, 0, 4, 3);
        add(0, 1, 2, 0, 1, 0, 8'h01, 0, 0,   0, 8'h01, 1, 2, 0, 4, 3);
        add(0, 0, 0, 0, 1, 1, 8'h40, 0, 1,   0, 8'h40, 0, 0, 0, 4, 3);
        add(0, 1, 0, 0, 0, 0, 8'h03, 0, 0,   0, 8'h03, 1, 0, 0, 4, 3);
        add(0, 0, 0, 4, 1, 0, 8'h01, 0, 0,   0, 8'h01, 0, 0, 4, 4, 3);
        add(0, 1, 9, 9, 0, 0, 8'h03, 0, 0,   0, 8'h03, 1, 9, 9, 4, 3);
        add(0, 2, 9, 0, 1, 0, 8'h10, 0, 0,   1, 8'h00, 2, 9, 0, 5, 3);
        add(0, 2, 9, 0, 1, 0, 8'h10, 0, 0,   0, 8'h10, 2, 9, 0, 5, 3);
        add(1, 5, 5, 5, 1, 1, 8'h03, 5, 1,   0, 8'h00, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.rs, v.rt, v.dest, v.uses, v.br, v.ctrl, v.xrd, v.xmr, i);
            #1;
            chk($sformatf("stall[%0d]", i), 64'(stall), 64'(v.e_stall));
            chk($sformatf("pcWrite[%0d]", i), 64'(pcWrite), 64'(!v.e_stall));
            chk($sformatf("if_idWrite[%0d]", i), 64'(if_idWrite), 64'(!v.e_stall));
            chk($sformatf("sat_stall[%0d]", i), 64'(s_stall), 64'(v.e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("ctrl[%0d]", i), 64'(ctrlOut), 64'(v.e_ctrl));
            chk($sformatf("regWr[%0d]", i), 64'(regWrOut), 64'(v.e_ctrl[0]));
            chk($sformatf("rs[%0d]", i), 64'(rsOut), 64'(v.e_rs));
            chk($sformatf("rt[%0d]", i), 64'(rtOut), 64'(v.e_rt));
            chk($sformatf("dest[%0d]", i), 64'(destOut), 64'(v.e_dest));
            chk($sformatf("data1[%0d]", i), 64'(d1Out), v.rst ? 64'h0 : 64'(32'hA000_0000 | i));
            chk($sformatf("data2[%0d]", i), 64'(d2Out), v.rst ? 64'h0 : 64'(32'hB000_0000 | i));
            chk($sformatf("imm[%0d]", i), 64'(immOut), v.rst ? 64'h0 : 64'(32'hFFFF_FF00 | i));
            chk($sformatf("count[%0d]", i), 64'(stallCount), 64'(v.e_cnt));
            chk($sformatf("sat_count[%0d]", i), 64'(s_stallCount), 64'(v.e_sat));
            chk($sformatf("sat_ctrl[%0d]", i), 64'(s_ctrlOut), 64'(v.e_ctrl));
            @(negedge clk);
        end

        // lw $5 then beq using Rt=5: two consecutive stalls, then the branch enters EX
        drive(0, 1, 5, 5, 0, 0, 8'h03, 0, 0, 100);
        #1 chk("seq_lw_stall", 64'(stall), 64'h0);
        @(negedge clk);
        drive(0, 1, 5, 0, 1, 1, 8'h40, 0, 0, 101);
        #1 chk("seq_brex_stall", 64'(stall), 64'h1);
        chk("seq_brex_pcWrite", 64'(pcWrite), 64'h0);
        @(negedge clk);
        chk("seq_bubble1", 64'(ctrlOut), 64'h0);
        drive(0, 1, 5, 0, 1, 1, 8'h40, 5, 1, 102);
        #1 chk("seq_brmem_stall", 64'(stall), 64'h1);
        @(negedge clk);
        drive(0, 1, 5, 0, 1, 1, 8'h40, 0, 0, 103);
        #1 chk("seq_release_stall", 64'(stall), 64'h0);
        chk("seq_release_ifid", 64'(if_idWrite), 64'h1);
        @(negedge clk);
        chk("seq_branch_ctrl", 64'(ctrlOut), 64'h40);
        chk("seq_count", 64'(stallCount), 64'h2);
        chk("seq_sat_count", 64'(s_stallCount), 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
